seq_divider: RTL and testbench



---
 rtl/seq_divider_pkg.sv | 22 ++
 rtl/seq_divider_step.sv | 26 ++
 rtl/seq_divider.sv | 135 +++++++++++++
 tb/tb_seq_divider.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/seq_divider_pkg.sv
// Shared definitions for the iterative RV32 divider: state encoding, width
// and the M-extension special-case result constants.
package seq_divider_pkg;

  localparam int DIV_WIDTH = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    CALC = ST_CALC,
    FIX  = ST_FIX,
    DONE = ST_DONE
  } div_state_t;

  localparam logic [DIV_WIDTH-1:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [DIV_WIDTH-1:0] INT_MIN       = 32'h8000_0000;

endpackage

// File: rtl/seq_divider_step.sv
// One restoring shift-and-subtract step, kept separate so the wide subtract
// can later be mapped onto a DSP slice or retimed.
module div_step
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_quo_msb,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_q_bit
);

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_trial;

  // The partial remainder is always below the divisor, so the shifted value
  // and the difference both fit 33 bits and bit 32 of the trial is its sign.
  assign w_shift = {i_rem, i_quo_msb};
  assign w_trial = w_shift - {1'b0, i_divisor};

  assign o_q_bit = ~w_trial[WIDTH];
  assign o_rem   = o_q_bit ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// Iterative signed/unsigned 32-bit divider with RISC-V M semantics:
// one quotient bit per cycle, fixed 33-cycle latency from accept to done.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

  div_state_t       r_state;
  div_state_t       w_state_next;
  logic [CW-1:0]    r_count;
  logic             r_q_neg;
  logic             r_r_neg;
  logic             r_div_zero;
  logic             r_overflow;
  logic [WIDTH-1:0] r_dividend_orig;
  logic [WIDTH-1:0] r_dmag;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;

  logic             w_dvd_neg;
  logic             w_dvs_neg;
  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dvs_mag;
  logic [WIDTH-1:0] w_rem_next;
  logic             w_q_bit;
  logic             w_last;
  logic [WIDTH-1:0] w_fix_q;
  logic [WIDTH-1:0] w_fix_r;

  assign w_dvd_neg = is_signed & dividend[WIDTH-1];
  assign w_dvs_neg = is_signed & divisor[WIDTH-1];
  assign w_dvd_mag = w_dvd_neg ? -dividend : dividend;
  assign w_dvs_mag = w_dvs_neg ? -divisor  : divisor;
  assign w_last    = (r_count == CW'(WIDTH - 1));

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .i_rem     (r_rem),
    .i_quo_msb (r_quo[WIDTH-1]),
    .i_divisor (r_dmag),
    .o_rem     (w_rem_next),
    .o_q_bit   (w_q_bit)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = CALC;
      CALC:    if (w_last) w_state_next = FIX;
      FIX:     w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_fix_q = r_q_neg ? -r_quo : r_quo;
    w_fix_r = r_r_neg ? -r_rem : r_rem;
    if (r_div_zero) begin
      w_fix_q = DIV_BY_ZERO_Q;
      w_fix_r = r_dividend_orig;
    end else if (r_overflow) begin
      w_fix_q = INT_MIN;
      w_fix_r = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= IDLE;
      r_count         <= '0;
      r_q_neg         <= 1'b0;
      r_r_neg         <= 1'b0;
      r_div_zero      <= 1'b0;
      r_overflow      <= 1'b0;
      r_dividend_orig <= '0;
      r_dmag          <= '0;
      r_rem           <= '0;
      r_quo           <= '0;
      r_quotient      <= '0;
      r_remainder     <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_q_neg         <= w_dvd_neg ^ w_dvs_neg;
            r_r_neg         <= w_dvd_neg;
            r_div_zero      <= (divisor == '0);
            r_overflow      <= is_signed && (dividend == INT_MIN) && (divisor == '1);
            r_dividend_orig <= dividend;
            r_dmag          <= w_dvs_mag;
            r_quo           <= w_dvd_mag;
            r_rem           <= '0;
            r_count         <= '0;
          end
        end
        CALC: begin
          // Dividend bits shift out of r_quo's top while quotient bits enter below.
          r_rem   <= w_rem_next;
          r_quo   <= {r_quo[WIDTH-2:0], w_q_bit};
          r_count <= r_count + CW'(1);
        end
        FIX: begin
          r_quotient  <= w_fix_q;
          r_remainder <= w_fix_r;
        end
        default: ;
      endcase
    end
  end

  assign quotient  = r_quotient;
  assign remainder = r_remainder;
  assign busy      = (r_state == CALC) || (r_state == FIX);
  assign done      = (r_state == DONE);

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: stimulus pushes expected results, a
// monitor pops and compares on every done pulse.
module tb_seq_divider;

  typedef struct {
    string       name;
    logic [31:0] q;
    logic [31:0] r;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        busy;
  logic        done;

  exp_t sb[$];
  int   n_tests;
  int   n_fail;

  seq_divider dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .is_signed (is_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (!reset && done) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_done: got q=%h r=%h, required no done", quotient, remainder);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (quotient !== e.q || remainder !== e.r) begin
          n_fail++;
          $display("FAIL %s: got q=%h r=%h, required q=%h r=%h",
                   e.name, quotient, remainder, e.q, e.r);
        end else begin
          $display("[TB] %s: q=%h r=%h ok", e.name, quotient, remainder);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  // Drive one start cycle; returns at the negedge after the accepting edge.
  task automatic issue(input string nm, input logic [31:0] a, input logic [31:0] b,
                       input logic s, input logic [31:0] eq, input logic [31:0] er,
                       input bit push);
    exp_t e;
    @(negedge clk);
    start     = 1'b1;
    is_signed = s;
    dividend  = a;
    divisor   = b;
    if (push) begin
      e.name = nm;
      e.q    = eq;
      e.r    = er;
      sb.push_back(e);
    end
    @(negedge clk);
    start     = 1'b0;
    is_signed = 1'($urandom);
    dividend  = $urandom;
    divisor   = $urandom;
  endtask

  // Counts edges since the accept edge until done is seen, bounded.
  task automatic wait_done(output int edges, output int busy_cyc);
    edges    = 0;
    busy_cyc = 0;
    while (!done && edges < 60) begin
      if (busy) busy_cyc++;
      @(negedge clk);
      edges++;
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL done_timeout: got no done after %0d cycles, required done", edges);
    end
  endtask

  task automatic run_div(input string nm, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic [31:0] eq, input logic [31:0] er);
    int edges;
    int busy_cyc;
    issue(nm, a, b, s, eq, er, 1'b1);
    wait_done(edges, busy_cyc);
    // Done appears after the 33rd edge following the accept edge.
    chk({nm, "_latency"}, 32'(edges), 32'd33);
    chk({nm, "_busy_cycles"}, 32'(busy_cyc), 32'd33);
    chk({nm, "_busy_in_done"}, {31'd0, busy}, 32'd0);
    @(negedge clk);
  endtask

  initial begin
    int edges;
    int busy_cyc;
    int saw_done;
    n_tests   = 0;
    n_fail    = 0;
    reset     = 1'b1;
    start     = 1'b0;
    is_signed = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(negedge clk);
    chk("reset_quotient", quotient, 32'd0);
    chk("reset_remainder", remainder, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    reset = 1'b0;

    run_div("u_100_div_7",    32'd100,        32'd7,          1'b0, 32'd14,         32'd2);
    run_div("s_m7_div_2",     32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF);
    run_div("s_7_div_m2",     32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1);
    run_div("s_m7_div_m2",    32'hFFFF_FFF9,  32'hFFFF_FFFE,  1'b1, 32'd3,          32'hFFFF_FFFF);
    run_div("s_m6_div_3",     32'hFFFF_FFFA,  32'd3,          1'b1, 32'hFFFF_FFFE,  32'd0);
    run_div("u_max_div_1",    32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF,  32'd0);
    run_div("u_5_div_0",      32'd5,          32'd0,          1'b0, 32'hFFFF_FFFF,  32'd5);
    run_div("s_5_div_0",      32'd5,          32'd0,          1'b1, 32'hFFFF_FFFF,  32'd5);
    run_div("s_intmin_div_m1", 32'h8000_0000, 32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0);
    run_div("u_intmin_div_max", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0,          32'h8000_0000);

    // Starts during CALC and during DONE must both be ignored.
    issue("u_1000_div_3", 32'd1000, 32'd3, 1'b0, 32'd333, 32'd1, 1'b1);
    repeat (9) @(negedge clk);
    start = 1'b1; dividend = 32'd7; divisor = 32'd7; is_signed = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_ignored_start", {31'd0, busy}, 32'd1);
    wait_done(edges, busy_cyc);
    start = 1'b1; dividend = 32'd50; divisor = 32'd5; is_signed = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("idle_after_start_in_done_busy", {31'd0, busy}, 32'd0);
    chk("idle_after_start_in_done_done", {31'd0, done}, 32'd0);
    repeat (3) @(negedge clk);
    chk("hold_quotient", quotient, 32'd333);
    chk("hold_remainder", remainder, 32'd1);

    // Reset mid-operation aborts without a done pulse.
    issue("aborted", 32'd123456, 32'd7, 1'b0, 32'd0, 32'd0, 1'b0);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_quotient", quotient, 32'd0);
    chk("abort_remainder", remainder, 32'd0);
    reset = 1'b0;
    saw_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) saw_done++;
    end
    chk("abort_no_done", 32'(saw_done), 32'd0);

    run_div("u_9_div_3", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0);

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
